toggle_pulse_receiver: RTL

//   Receive end of the toggle-event link. The sender flips a T flip-flop

---
 rtl/toggle_pulse_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/toggle_pulse_receiver.sv
// toggle_pulse_receiver
//   Receive end of a toggle-event link. The sender flips a level once per
//   event; this block synchronises that level, converts each transition into
//   one buffered event offered on a valid/ready handshake, and returns a
//   toggle acknowledge per accepted event. Accepted events are counted and a
//   sticky flag records any event dropped because one was already pending.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   synchronous active-low reset
//   t_in       in   toggle level from sender (asynchronous to clk)
//   evt_ready  in   consumer can take the pending event
//   evt_valid  out  one event is pending (registered)
//   ack_t      out  toggles once per accepted event
//   q, q_bar   out  synchronised t_in level and its complement
//   evt_count  out  accepted-event count, wraps silently
//   overrun    out  sticky: an event was dropped
module toggle_pulse_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 t_in,
   input  logic                 evt_ready,
   output logic                 evt_valid,
   output logic                 ack_t,
   output logic                 q,
   output logic                 q_bar,
   output logic [CNT_WIDTH-1:0] evt_count,
   output logic                 overrun
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   // INIT covers init counter values 0..SYNC_STAGES, i.e. SYNC_STAGES+1 cycles,
   // long enough for the synchroniser and prev to settle on the t_in level.
   localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   state_e                 state_q, state_d;
   logic [2:0]             init_cnt_q, init_cnt_d;
   logic                   evt_valid_q, evt_valid_d;
   logic                   ack_q, ack_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovr_q, ovr_d;
   logic                   tgl_edge;
   logic                   accept;

   assign q         = sync_q[SYNC_STAGES-1];
   assign q_bar     = ~q;
   assign evt_valid = evt_valid_q;
   assign ack_t     = ack_q;
   assign evt_count = cnt_q;
   assign overrun   = ovr_q;

   // Any level change of the synchronised input is one sender event.
   assign tgl_edge = q ^ prev_q;
   assign accept   = evt_valid_q & evt_ready;

   always_ff @(posedge clk) begin
      if (!clr) begin
         sync_q      <= '0;
         prev_q      <= 1'b0;
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         evt_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         cnt_q       <= '0;
         ovr_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], t_in};
         prev_q      <= q;
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         evt_valid_q <= evt_valid_d;
         ack_q       <= ack_d;
         cnt_q       <= cnt_d;
         ovr_q       <= ovr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      evt_valid_d = evt_valid_q;
      ack_d       = ack_q;
      cnt_d       = cnt_q;
      ovr_d       = ovr_q;
      case (state_q)
         ST_INIT: begin
            // Edges seen here come from the synchroniser filling after reset.
            if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
            else                         init_cnt_d = init_cnt_q + 3'd1;
         end
         ST_IDLE: begin
            if (tgl_edge) begin
               state_d     = ST_PEND;
               evt_valid_d = 1'b1;
            end
         end
         ST_PEND: begin
            if (accept) begin
               ack_d = ~ack_q;
               cnt_d = cnt_q + 1'b1;
               // A new event arriving with the accept takes over the buffer.
               if (!tgl_edge) begin
                  state_d     = ST_IDLE;
                  evt_valid_d = 1'b0;
               end
            end else if (tgl_edge) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_INIT;
            init_cnt_d  = '0;
            evt_valid_d = 1'b0;
         end
      endcase
   end

endmodule
